serial_tx_arbiter: RTL

Shares the processor's single byte-wide serial transmit port between two requesters: the CPU's memory-mapped serial store path (requester 0) and the debug/trace monitor (requester 1). The arbiter locks the port to one requester until it sends an end-of-line byte, so text lines never interleave. A lock timeout stops an idle owner from holding the port. A one-entry output register drives `serial_out`/`serial_wren_out` under `serial_ready_in` backpressure.

---
 rtl/serial_pkg.sv | 47 ++++
 rtl/serial_tx_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//
// Shared definitions for the serial transmit path:
//   EOL_DEFAULT           - default end-of-line byte that releases a line lock
//   LOCK_TIMEOUT_DEFAULT  - default idle-owner cycles before a forced release
//   arb_state_t           - arbiter state encoding (ARB_IDLE / ARB_LOCKED)
//   req_idx_t             - requester index (REQ_CPU = 0, REQ_DEBUG = 1)
//   rr_pick()             - round-robin grant decision for the two requesters
//   idle_cnt_width()      - width of the idle counter for a given timeout
// -----------------------------------------------------------------------------
package serial_pkg;

  localparam logic [7:0] EOL_DEFAULT          = 8'h0A;
  localparam int         LOCK_TIMEOUT_DEFAULT = 255;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef logic [0:0] req_idx_t;

  localparam req_idx_t REQ_CPU   = 1'b0;
  localparam req_idx_t REQ_DEBUG = 1'b1;

  // A tie goes to whichever requester did not hold the port last; otherwise
  // the only valid requester wins.
  function automatic req_idx_t rr_pick(input logic v0, input logic v1,
                                       input req_idx_t last);
    if (v0 && v1) begin
      return ~last;
    end else if (v1) begin
      return REQ_DEBUG;
    end
    return REQ_CPU;
  endfunction

  // A disabled timeout (0) still gets a 1-bit counter so the vector is legal.
  function automatic int idle_cnt_width(input int timeout);
    if (timeout < 1) begin
      return 1;
    end
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// serial_tx_arbiter
//
// Shares the single byte-wide serial transmit port between the CPU serial
// store path (requester 0) and the debug/trace monitor (requester 1). Once a
// requester is granted, the port stays locked to it until it sends EOL_CHAR,
// so text lines never interleave. An owner that stops presenting bytes for
// LOCK_TIMEOUT locked cycles loses the lock (0 disables the timeout). A
// one-entry output register drives the sink under serial_ready_in backpressure.
//
// Handshake: every byte interface here is valid/ready. A byte moves on a
// rising edge where valid and ready are both 1; a source holds valid and data
// stable until that happens. serial_wren_out/serial_ready_in follow the same
// rule, with serial_wren_out as the valid.
//
// Parameters:
//   EOL_CHAR      - byte that ends a line and releases the lock
//   LOCK_TIMEOUT  - idle-owner cycles before a forced release, 0 = never
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   synchronous, active-high
//   req0_data        in   [7:0] requester 0 byte
//   req0_valid       in   requester 0 byte available
//   req0_ready       out  requester 0 byte accepted this cycle when valid
//   req1_data        in   [7:0] requester 1 byte
//   req1_valid       in   requester 1 byte available
//   req1_ready       out  requester 1 byte accepted this cycle when valid
//   serial_ready_in  in   sink can take a byte this cycle
//   serial_out       out  [7:0] byte to the sink
//   serial_wren_out  out  serial_out valid
//   owner            out  current/last grant index
//   locked           out  port locked to owner (doubles as the FSM state view)
// -----------------------------------------------------------------------------
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter logic [7:0] EOL_CHAR     = EOL_DEFAULT,
  parameter int         LOCK_TIMEOUT = LOCK_TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       serial_ready_in,
  output logic [7:0] serial_out,
  output logic       serial_wren_out,
  output logic       owner,
  output logic       locked
);

  localparam int CNT_W = idle_cnt_width(LOCK_TIMEOUT);

  // Value the idle counter holds during the last idle cycle before release;
  // the release edge is the one on which the count would reach LOCK_TIMEOUT.
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((LOCK_TIMEOUT > 0) ? (LOCK_TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state;
  req_idx_t         owner_q;
  req_idx_t         rr_last;
  logic [CNT_W-1:0] idle_cnt;
  logic             out_valid;
  logic [7:0]       out_data;

  logic             is_locked;
  logic             can_load;
  logic             owner_valid;
  logic [7:0]       owner_data;
  logic             xfer;
  logic             drain;
  logic             timeout_hit;

  assign is_locked   = (state == ARB_LOCKED);

  // The output register can take a new byte if it is empty or is being
  // drained on this same edge; this is the only path from serial_ready_in
  // to the requester readies.
  assign can_load    = !out_valid || serial_ready_in;

  assign owner_valid = (owner_q == REQ_DEBUG) ? req1_valid : req0_valid;
  assign owner_data  = (owner_q == REQ_DEBUG) ? req1_data  : req0_data;

  assign req0_ready  = is_locked && (owner_q == REQ_CPU)   && can_load;
  assign req1_ready  = is_locked && (owner_q == REQ_DEBUG) && can_load;

  assign xfer        = is_locked && owner_valid && can_load;
  assign drain       = out_valid && serial_ready_in;
  assign timeout_hit = (LOCK_TIMEOUT != 0) && (idle_cnt == TO_LAST);

  assign serial_out      = out_data;
  assign serial_wren_out = out_valid;
  assign owner           = owner_q;
  assign locked          = is_locked;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ARB_IDLE;
      owner_q   <= REQ_CPU;
      rr_last   <= REQ_DEBUG;
      idle_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      // Output register. A release never flushes it; the buffered byte
      // leaves on its own once the sink is ready.
      if (xfer) begin
        out_data  <= owner_data;
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          // No byte is accepted in IDLE; the grant takes effect next cycle.
          if (req0_valid || req1_valid) begin
            state    <= ARB_LOCKED;
            owner_q  <= rr_pick(req0_valid, req1_valid, rr_last);
            idle_cnt <= '0;
          end
        end

        ARB_LOCKED: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (owner_data == EOL_CHAR) begin
              state   <= ARB_IDLE;
              rr_last <= owner_q;
            end
          end else if (!owner_valid) begin
            // Only an owner with nothing to send counts as idle; a byte held
            // back by a stalled sink leaves the counter alone.
            if (timeout_hit) begin
              state    <= ARB_IDLE;
              rr_last  <= owner_q;
              idle_cnt <= '0;
            end else if (LOCK_TIMEOUT != 0) begin
              idle_cnt <= idle_cnt + CNT_ONE;
            end
          end
        end

        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
